// File: rtl/xadc_drp_scheduler.sv
// Round-robin scheduler sharing the single XADC DRP read port among N_REQ requesters.
// Holds one pending read per requester and returns each result (or a timeout) as a one-cycle strobe.
module xadc_drp_scheduler #(
    parameter int N_REQ   = 3,
    parameter int ADDR_W  = 7,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic                       clk_1MHz,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           i_req_pulse,
    input  logic [N_REQ*ADDR_W-1:0]    i_req_addr,
    output logic [N_REQ-1:0]           o_rsp_valid,
    output logic [15:0]                o_rsp_data,
    output logic                       o_rsp_err,
    output logic [ADDR_W-1:0]          o_drp_daddr,
    output logic                       o_drp_den,
    input  logic                       i_drp_drdy,
    input  logic [15:0]                i_drp_do,
    output logic                       o_busy,
    output logic [$clog2(N_REQ)-1:0]   o_grant_id
);

    localparam int GW = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam logic [GW-1:0]    LAST_IDX = GW'(N_REQ - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = {TO_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [N_REQ-1:0]    r_pending;
    logic [ADDR_W-1:0]   r_slot [N_REQ];
    logic [GW-1:0]       r_last_grant;
    logic [TO_W-1:0]     r_timer;

    logic [N_REQ-1:0]    w_clr;
    logic [N_REQ-1:0]    w_accept;
    logic [GW-1:0]       w_cand;
    logic [GW-1:0]       w_rr_grant;
    logic                w_rr_found;
    logic [TO_W-1:0]     w_timer_nxt;
    logic [GW-1:0]       w_last_nxt;
    logic [N_REQ-1:0]    w_valid_nxt;
    logic [15:0]         w_data_nxt;
    logic                w_err_nxt;
    logic [ADDR_W-1:0]   w_daddr_nxt;
    logic                w_den_nxt;
    logic                w_busy_nxt;
    logic [GW-1:0]       w_grant_nxt;

    // A pulse is accepted when its slot is free or is being released this very cycle.
    assign w_accept = i_req_pulse & (~r_pending | w_clr);

    // Round-robin search starting just after the last served requester, wrapping at N_REQ-1.
    always_comb begin
        w_cand     = r_last_grant;
        w_rr_grant = r_last_grant;
        w_rr_found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_cand == LAST_IDX) begin
                w_cand = {GW{1'b0}};
            end else begin
                w_cand = w_cand + GW'(1);
            end
            if (!w_rr_found && r_pending[w_cand]) begin
                w_rr_grant = w_cand;
                w_rr_found = 1'b1;
            end else begin
                w_rr_found = w_rr_found;
            end
        end
    end

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_last_nxt  = r_last_grant;
        w_valid_nxt = {N_REQ{1'b0}};
        w_data_nxt  = o_rsp_data;
        w_err_nxt   = o_rsp_err;
        w_daddr_nxt = o_drp_daddr;
        w_den_nxt   = 1'b0;
        w_grant_nxt = o_grant_id;
        w_clr       = {N_REQ{1'b0}};
        case (r_state)
            S_IDLE: begin
                if (r_pending != {N_REQ{1'b0}}) begin
                    w_state_nxt = S_ISSUE;
                    w_grant_nxt = w_rr_grant;
                    w_daddr_nxt = r_slot[w_rr_grant];
                    w_den_nxt   = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
                w_timer_nxt = {TO_W{1'b0}};
            end
            S_WAIT: begin
                if (i_drp_drdy) begin
                    w_data_nxt  = i_drp_do;
                    w_err_nxt   = 1'b0;
                    w_valid_nxt = ONE_HOT0 << o_grant_id;
                    w_state_nxt = S_RESP;
                end else if (r_timer == TO_LAST) begin
                    w_data_nxt  = 16'h0000;
                    w_err_nxt   = 1'b1;
                    w_valid_nxt = ONE_HOT0 << o_grant_id;
                    w_state_nxt = S_RESP;
                end else if (r_timer != TO_MAX) begin
                    w_timer_nxt = r_timer + TO_W'(1);
                end else begin
                    w_timer_nxt = r_timer;
                end
            end
            S_RESP: begin
                w_clr       = ONE_HOT0 << o_grant_id;
                w_last_nxt  = o_grant_id;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // FSM state, timer and registered outputs.
    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_timer      <= {TO_W{1'b0}};
            r_last_grant <= LAST_IDX;
            o_rsp_valid  <= {N_REQ{1'b0}};
            o_rsp_data   <= 16'h0000;
            o_rsp_err    <= 1'b0;
            o_drp_daddr  <= {ADDR_W{1'b0}};
            o_drp_den    <= 1'b0;
            o_busy       <= 1'b0;
            o_grant_id   <= LAST_IDX;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_last_grant <= w_last_nxt;
            o_rsp_valid  <= w_valid_nxt;
            o_rsp_data   <= w_data_nxt;
            o_rsp_err    <= w_err_nxt;
            o_drp_daddr  <= w_daddr_nxt;
            o_drp_den    <= w_den_nxt;
            o_busy       <= w_busy_nxt;
            o_grant_id   <= w_grant_nxt;
        end
    end

    // Pending bits and address slots; a set in the release cycle overrides the clear.
    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= {N_REQ{1'b0}};
            for (int i = 0; i < N_REQ; i++) begin
                r_slot[i] <= {ADDR_W{1'b0}};
            end
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_accept;
            for (int i = 0; i < N_REQ; i++) begin
                if (w_accept[i]) begin
                    r_slot[i] <= i_req_addr[i*ADDR_W +: ADDR_W];
                end
            end
        end
    end

endmodule
